// File: rtl/pll_ctrl_pkg.sv
// Shared types and defaults for the PLL lock supervisor.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RST,
    S_WAIT,
    S_STABLE,
    S_RUN,
    S_FAIL
  } pll_ctrl_state_e;

  localparam int unsigned RST_CYC_DEF      = 16;
  localparam int unsigned LOCK_STABLE_DEF  = 1024;
  localparam int unsigned LOCK_TIMEOUT_DEF = 65536;
  localparam int unsigned MAX_RETRY_DEF    = 7;

  // Bits needed to hold the value n (at least 1).
  function automatic int unsigned clog2w(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((n >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low reset to zero.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL lock supervisor: resets the PLL, qualifies lock, releases the system
// reset, retries on timeout and parks in FAIL after a bounded number of attempts.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYC      = RST_CYC_DEF,
  parameter int unsigned LOCK_STABLE  = LOCK_STABLE_DEF,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int unsigned MAX_RETRY    = MAX_RETRY_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fail,
  output logic [7:0] relock_cnt
);

  localparam int unsigned CNT_MAX = (RST_CYC > LOCK_STABLE) ? RST_CYC : LOCK_STABLE;
  localparam int unsigned CW      = clog2w(CNT_MAX);
  localparam int unsigned TW      = clog2w(LOCK_TIMEOUT);
  localparam int unsigned RW      = clog2w(MAX_RETRY);

  pll_ctrl_state_e state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [TW-1:0]   tmo, tmo_nxt;
  logic [RW-1:0]   retry, retry_nxt;
  logic [7:0]      relock_nxt;
  logic            timeout;
  logic            lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    tmo_nxt    = tmo;
    retry_nxt  = retry;
    relock_nxt = relock_cnt;
    timeout    = 1'b0;

    if (state == S_WAIT || state == S_STABLE) begin
      tmo_nxt = tmo + 1'b1;
      timeout = (tmo_nxt == TW'(LOCK_TIMEOUT));
    end

    case (state)
      S_RST: begin
        if (cnt == CW'(RST_CYC - 1)) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
          tmo_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (lock_s) begin
          state_nxt = S_STABLE;
          cnt_nxt   = CW'(1);
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end else if (cnt == CW'(LOCK_STABLE - 1)) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_nxt = S_RST;
          cnt_nxt   = '0;
          if (relock_cnt != 8'hFF) relock_nxt = relock_cnt + 8'd1;
        end
      end
      S_FAIL: begin
        if (restart) begin
          state_nxt = S_RST;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      end
      default: begin
        state_nxt = S_RST;
        cnt_nxt   = '0;
      end
    endcase

    // Timeout overrides whatever the per-state logic decided, including RUN entry.
    if (timeout) begin
      cnt_nxt = '0;
      tmo_nxt = '0;
      if (retry == RW'(MAX_RETRY)) begin
        state_nxt = S_FAIL;
        retry_nxt = retry;
      end else begin
        state_nxt = S_RST;
        retry_nxt = retry + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RST;
      cnt        <= '0;
      tmo        <= '0;
      retry      <= '0;
      relock_cnt <= '0;
      pll_reset  <= 1'b1;
      sys_rst_n  <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      tmo        <= tmo_nxt;
      retry      <= retry_nxt;
      relock_cnt <= relock_nxt;
      pll_reset  <= (state_nxt == S_RST) || (state_nxt == S_FAIL);
      sys_rst_n  <= (state_nxt == S_RUN);
      locked     <= (state_nxt == S_RUN);
      fail       <= (state_nxt == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with RST_CYC=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, MAX_RETRY=2.
module tb_pll_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_lock = 1'b0;
  logic       restart = 1'b0;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       locked;
  logic       fail;
  logic [7:0] relock_cnt;

  int checks = 0;
  int errors = 0;

  pll_lock_ctrl #(
    .RST_CYC      (4),
    .LOCK_STABLE  (8),
    .LOCK_TIMEOUT (64),
    .MAX_RETRY    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .restart    (restart),
    .pll_reset  (pll_reset),
    .sys_rst_n  (sys_rst_n),
    .locked     (locked),
    .fail       (fail),
    .relock_cnt (relock_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    pll_lock = 1'b0;
    restart  = 1'b0;
    tick();
    tick();
    checks++;
    if (pll_reset !== 1'b1) begin errors++; $display("FAIL reset_pll_reset got %b want 1", pll_reset); end
    checks++;
    if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL reset_sys_rst_n got %b want 0", sys_rst_n); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++;
    if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %b want 0", fail); end
    checks++;
    if (relock_cnt !== 8'd0) begin errors++; $display("FAIL reset_relock_cnt got %0d want 0", relock_cnt); end
  endtask

  task automatic test_clean_boot();
    logic exp;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp = (k < 4);
      checks++;
      if (pll_reset !== exp) begin
        errors++; $display("FAIL boot_pll_reset edge %0d got %b want %b", k, pll_reset, exp);
      end
    end
    pll_lock = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      tick();
      exp = (j >= 9);
      checks++;
      if (locked !== exp || sys_rst_n !== exp) begin
        errors++; $display("FAIL boot_release edge %0d got locked=%b sys_rst_n=%b want %b", j, locked, sys_rst_n, exp);
      end
    end
  endtask

  task automatic lose_lock(input logic [7:0] exp_cnt, input string name);
    logic exp;
    pll_lock = 1'b0;
    for (int j = 0; j <= 2; j++) begin
      tick();
      exp = (j < 2);
      checks++;
      if (locked !== exp || sys_rst_n !== exp || pll_reset !== !exp) begin
        errors++; $display("FAIL %s_drop edge %0d got locked=%b sys_rst_n=%b pll_reset=%b want locked=%b", name, j, locked, sys_rst_n, pll_reset, exp);
      end
    end
    checks++;
    if (relock_cnt !== exp_cnt) begin
      errors++; $display("FAIL %s_relock_cnt got %0d want %0d", name, relock_cnt, exp_cnt);
    end
  endtask

  task automatic test_lock_loss();
    logic exp;
    lose_lock(8'd1, "loss");
    pll_lock = 1'b1;
    for (int m = 1; m <= 13; m++) begin
      tick();
      exp = (m >= 12);
      checks++;
      if (locked !== exp || sys_rst_n !== exp) begin
        errors++; $display("FAIL loss_relock edge %0d got locked=%b want %b", m, locked, exp);
      end
    end
  endtask

  task automatic test_stable_glitch();
    logic exp;
    lose_lock(8'd2, "glitch");
    pll_lock = 1'b1;
    for (int m = 1; m <= 23; m++) begin
      if (m == 10) pll_lock = 1'b0;
      if (m == 13) pll_lock = 1'b1;
      tick();
      exp = (m >= 22);
      checks++;
      if (locked !== exp) begin
        errors++; $display("FAIL glitch_requal edge %0d got locked=%b want %b", m, locked, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic exp;
    lose_lock(8'd3, "mid");
    pll_lock = 1'b1;
    for (int m = 1; m <= 12; m++) tick();
    exp = 1'b1;
    checks++;
    if (locked !== exp) begin errors++; $display("FAIL mid_in_run got locked=%b want 1", locked); end
    #3 rst_n = 1'b0;
    pll_lock = 1'b0;
    #1;
    checks++;
    if (pll_reset !== 1'b1 || sys_rst_n !== 1'b0 || locked !== 1'b0 || fail !== 1'b0) begin
      errors++; $display("FAIL mid_async_outputs got pll_reset=%b sys_rst_n=%b locked=%b fail=%b want 1 0 0 0",
                         pll_reset, sys_rst_n, locked, fail);
    end
    checks++;
    if (relock_cnt !== 8'd0) begin errors++; $display("FAIL mid_async_relock_cnt got %0d want 0", relock_cnt); end
    tick();
  endtask

  task automatic test_never_lock();
    int   falls;
    int   fail_edge;
    logic prev;
    logic exp;
    falls     = 0;
    fail_edge = 0;
    @(negedge clk);
    rst_n = 1'b1;
    prev  = pll_reset;
    for (int k = 1; k <= 210; k++) begin
      tick();
      if (prev && !pll_reset) falls++;
      prev = pll_reset;
      if (fail && fail_edge == 0) fail_edge = k;
    end
    checks++;
    if (falls !== 3) begin errors++; $display("FAIL never_pulses got %0d want 3", falls); end
    checks++;
    if (fail_edge !== 204) begin errors++; $display("FAIL never_fail_edge got %0d want 204", fail_edge); end
    checks++;
    if (fail !== 1'b1 || pll_reset !== 1'b1 || sys_rst_n !== 1'b0) begin
      errors++; $display("FAIL never_park got fail=%b pll_reset=%b sys_rst_n=%b want 1 1 0", fail, pll_reset, sys_rst_n);
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if (fail !== 1'b0 || pll_reset !== 1'b1) begin
      errors++; $display("FAIL restart_leave got fail=%b pll_reset=%b want 0 1", fail, pll_reset);
    end
    for (int m = 1; m <= 5; m++) begin
      tick();
      exp = (m < 4);
      checks++;
      if (pll_reset !== exp) begin
        errors++; $display("FAIL restart_pll_reset edge %0d got %b want %b", m, pll_reset, exp);
      end
    end
  endtask

  task automatic test_saturation();
    int n;
    pll_lock = 1'b1;
    n = 0;
    while (locked !== 1'b1 && n < 80) begin tick(); n++; end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL sat_first_lock got locked=%b want 1", locked); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL restart_ignored_in_run got locked=%b want 1", locked); end
    for (int i = 1; i <= 260; i++) begin
      pll_lock = 1'b0;
      n = 0;
      while (locked !== 1'b0 && n < 10) begin tick(); n++; end
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL sat_drop loss %0d got locked=%b want 0", i, locked); end
      pll_lock = 1'b1;
      n = 0;
      while (locked !== 1'b1 && n < 40) begin tick(); n++; end
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL sat_relock loss %0d got locked=%b want 1", i, locked); end
      if (i == 5 || i == 254 || i == 255) begin
        checks++;
        if (relock_cnt !== 8'(i)) begin errors++; $display("FAIL sat_count loss %0d got %0d want %0d", i, relock_cnt, i); end
      end
    end
    checks++;
    if (relock_cnt !== 8'd255) begin errors++; $display("FAIL sat_final got %0d want 255", relock_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean_boot();
    test_lock_loss();
    test_stable_glitch();
    test_mid_reset();
    test_never_lock();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

Lock supervisor for the rPLL wrapper.
- Drives the PLL `reset` input and consumes its `lock` output.
- Qualifies lock, then releases a synchronous-domain system reset.
- On lock loss it re-resets the PLL; after a bounded number of failed attempts it parks in a fail state.
- Runs on the PLL reference clock, i.e. the same clock fed to the PLL `clkin`, never on a PLL output.

## Interface
Parameters:
- `RST_CYC`, 16: cycles `pll_reset` is held high per attempt (≥2).
- `LOCK_STABLE`, 1024: consecutive synchronized-lock-high cycles required before release (≥2).
- `LOCK_TIMEOUT`, 65536: cycles allowed from end of PLL reset to reaching RUN (> `LOCK_STABLE`+2).
- `MAX_RETRY`, 7: re-attempts after the first before FAIL (0..255).

Ports:
- `clk` input 1: reference clock (same net as PLL `clkin`).
- `rst_n` input 1: asynchronous active-low reset.
- `pll_lock` input 1: PLL lock, asynchronous to `clk`.
- `restart` input 1: single-cycle pulse; leaves FAIL.
- `pll_reset` output 1: to PLL `reset`, active high.
- `sys_rst_n` output 1: downstream reset, active low, high only in RUN.
- `locked` output 1: qualified lock status, equals state==RUN.
- `fail` output 1: high in FAIL.
- `relock_cnt` output 8: saturating count of lock losses seen in RUN.

## Operation
- `pll_lock` passes through a 2-flop synchronizer to produce `lock_s`; only `lock_s` is used.
- The state machine is Moore. All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- `rst_n` low (asynchronous), applied immediately:
  - state=S_RST; `pll_reset`=1; `sys_rst_n`=0; `locked`=0; `fail`=0; `relock_cnt`=0.
  - retry=0; all counters 0.
- S_RST: `pll_reset`=1. After `RST_CYC` cycles in state, go to S_WAIT and clear the timeout counter.
- S_WAIT: `pll_reset`=0. If `lock_s`=1, go to S_STABLE with stable count=1.
- S_STABLE:
  - `lock_s`=0: go to S_WAIT and clear the stable count. The timeout counter is not cleared.
  - Stable count reaches `LOCK_STABLE`: go to S_RUN and clear retry.
- Timeout:
  - The timeout counter runs in S_WAIT and S_STABLE.
  - When it reaches `LOCK_TIMEOUT`: if retry==`MAX_RETRY`, go to S_FAIL; otherwise retry+1 and go to S_RST.
  - Timeout has priority over the S_STABLE→S_RUN transition on the same cycle.
- S_RUN: `sys_rst_n`=1, `locked`=1. If `lock_s`=0, `relock_cnt` increments (saturating at 255), then go to S_RST.
- S_FAIL: `pll_reset`=1, `fail`=1, `sys_rst_n`=0. If `restart`=1, clear retry and go to S_RST.
- `restart` is ignored in every state other than S_FAIL.

## Timing
- Power-up: `rst_n` rises before edge 1.
  - `pll_reset` falls after edge `RST_CYC`.
- Lock qualification: with `pll_lock` first sampled high at edge 0 while in S_WAIT:
  - `lock_s`=1 after edge 1.
  - S_STABLE entered after edge 2.
  - S_RUN, `sys_rst_n`=1 and `locked`=1 after edge `LOCK_STABLE`+1.
- Lock loss: `pll_lock` first sampled low at edge 0 in RUN.
  - `sys_rst_n`=0, `locked`=0, `pll_reset`=1 and `relock_cnt` updated, all after edge 2.
- A lock glitch shorter than one clock period may be missed; this is acceptable.
- A `lock_s` drop on the cycle the stable count would complete keeps the FSM out of RUN (returns to S_WAIT).
- `relock_cnt` holds across retries and FAIL; only `rst_n` clears it.

## Structure
- Package `pll_ctrl_pkg`:
  - state enum `pll_ctrl_state_e` {S_RST, S_WAIT, S_STABLE, S_RUN, S_FAIL}.
  - default-parameter localparams.
  - function `clog2w` for counter widths.
- Sub-module `sync_2ff` (width 1, async active-low reset to 0) for `pll_lock`.
- One shared cycle counter for RST/STABLE, one timeout counter and one retry counter. Counter widths are derived from the parameters.

## Test plan
Bench parameters: `RST_CYC`=4, `LOCK_STABLE`=8, `LOCK_TIMEOUT`=64, `MAX_RETRY`=2.
- Clean boot: release `rst_n`, raise `pll_lock` 10 cycles later and hold it.
  - Required: `pll_reset` high for exactly 4 cycles.
  - Required: `sys_rst_n` and `locked` rise exactly 9 edges after `pll_lock` is first sampled.
- Stable glitch: in S_STABLE, drop `pll_lock` for 3 cycles at stable count 5.
  - Required: no RUN entry; the full 8-cycle qualification restarts.
- Lock loss in RUN: drop `pll_lock`.
  - Required: `sys_rst_n`=0 and `pll_reset`=1 two edges later; `relock_cnt`=1.
  - Restore lock: RUN is re-entered.
- Never lock: hold `pll_lock`=0.
  - Required: 3 `pll_reset` pulses, then `fail`=1 with `pll_reset` held high.
  - Pulse `restart`: `fail`=0 and a new 4-cycle reset.
- Mid-operation reset: assert `rst_n`=0 while in RUN with `relock_cnt`=3.
  - Required: all outputs go to reset values with no clock edge, and `relock_cnt`=0.
- Saturation: force 260 lock losses in RUN. Required: `relock_cnt` reads 255.
